// File: rtl/quet_12led_pkg.sv
// Shared constants for the 12-digit multiplexed seven-segment scanner:
// digit count, active-low glyph patterns (bit order g..a), scan state encoding.
package quet_12led_pkg;

    localparam int unsigned NUM_DIGITS = 12;
    localparam logic [3:0]  IDX_LAST   = 4'd11;

    // Scan FSM encoding
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    // Active-low glyphs, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

    // Registered display drive, all fields active-low
    typedef struct packed {
        logic [NUM_DIGITS-1:0] anode;
        logic [6:0]            sseg;
        logic                  dp;
    } disp_t;

    localparam disp_t DISP_OFF = '{anode: ANODE_OFF, sseg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational digit-code to active-low seven-segment glyph lookup.
// Codes 0-9 give decimal glyphs, 0xA gives a dash, 0xB-0xF are blank.
module bcd_to_7seg
    import quet_12led_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Glyph table
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_DASH;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/quet_12led.sv
// Twelve-digit multiplexed seven-segment scanner. Each scan tick ends the
// current digit slot, inserts GUARD_CYC all-anodes-off cycles to kill ghosting,
// then shows the next digit. All display outputs are registered.
module quet_12led
    import quet_12led_pkg::*;
#(
    parameter int unsigned GUARD_CYC = 4
) (
    input  logic                    ckht,
    input  logic                    rst_n,
    input  logic                    ena_scan,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   ena_12led,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              sseg,
    output logic                    dp
);

    localparam logic [3:0] GCNT_LAST = 4'(GUARD_CYC - 1);

    logic [0:0] r_state;
    logic [3:0] r_idx;
    logic [3:0] r_gcnt;
    disp_t      r_disp;

    logic [0:0]            w_state_nxt;
    logic [3:0]            w_idx_nxt;
    logic [3:0]            w_gcnt_nxt;
    disp_t                 w_disp_nxt;
    logic [3:0]            w_idx_safe;
    logic [3:0]            w_idx_inc;
    logic [3:0]            w_code;
    logic [6:0]            w_glyph;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_onehot;

    // Out-of-range indices can only come from upsets; fold them onto digit 0
    assign w_idx_safe = (r_idx > IDX_LAST) ? 4'd0 : r_idx;
    assign w_idx_inc  = (r_idx >= IDX_LAST) ? 4'd0 : r_idx + 4'd1;
    assign w_code     = data_in[{w_idx_safe, 2'b00} +: 4];
    assign w_lit      = ena_12led[w_idx_safe];
    assign w_onehot   = NUM_DIGITS'(1) << w_idx_safe;

    bcd_to_7seg u_glyph (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    // Scan FSM next state: ticks only count while a digit is showing
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gcnt_nxt  = r_gcnt;
        case (r_state)
            ST_SHOW: begin
                if (ena_scan) begin
                    w_state_nxt = ST_BLANK;
                    w_gcnt_nxt  = 4'd0;
                end
            end
            default: begin
                if (r_gcnt == GCNT_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_idx_nxt   = w_idx_inc;
                    w_gcnt_nxt  = 4'd0;
                end else begin
                    w_gcnt_nxt = r_gcnt + 4'd1;
                end
            end
        endcase
    end

    // Display drive from the current state; a masked digit keeps its slot but stays dark
    always_comb begin
        w_disp_nxt = DISP_OFF;
        if (r_state == ST_SHOW) begin
            w_disp_nxt.anode = w_lit ? ~w_onehot : ANODE_OFF;
            w_disp_nxt.sseg  = w_glyph;
            w_disp_nxt.dp    = ~(dp_in[w_idx_safe] & w_lit);
        end
    end

    // State, counters and output registers; idx resets to 11 so the first slot is digit 0
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_idx   <= IDX_LAST;
            r_gcnt  <= 4'd0;
            r_disp  <= DISP_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_disp  <= w_disp_nxt;
        end
    end

    assign anode = r_disp.anode;
    assign sseg  = r_disp.sseg;
    assign dp    = r_disp.dp;

endmodule

// File: tb/tb_quet_12led.sv
// Scoreboard bench for quet_12led: stimulus queues the expected sequence of
// distinct display states; the monitor pops one entry per output change and
// checks the run length of the blanking gaps.
module tb_quet_12led;

    logic        ckht = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena_scan = 1'b0;
    logic [47:0] data_in;
    logic [11:0] ena_12led;
    logic [11:0] dp_in;
    logic [11:0] anode;
    logic [6:0]  sseg;
    logic        dp;

    typedef struct {
        logic [11:0] an;
        logic [6:0]  ss;
        logic        dp;
        int          len;   // expected run length in cycles, 0 = unchecked
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 1'b0;

    // Hand-derived active-low glyphs (g..a) for codes 0..15
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Digits 11..0 = C A 9 8 7 6 1 4 3 2 0 5
    localparam logic [47:0] DATA = {4'hC, 4'hA, 4'h9, 4'h8, 4'h7, 4'h6,
                                    4'h1, 4'h4, 4'h3, 4'h2, 4'h0, 4'h5};

    quet_12led #(.GUARD_CYC(4)) dut (
        .ckht      (ckht),
        .rst_n     (rst_n),
        .ena_scan  (ena_scan),
        .data_in   (data_in),
        .ena_12led (ena_12led),
        .dp_in     (dp_in),
        .anode     (anode),
        .sseg      (sseg),
        .dp        (dp)
    );

    always #5 ckht = ~ckht;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // Monitor: sampled on the falling edge, one queue entry per output change
    logic [19:0] prev;
    logic [19:0] now;
    bit          started = 1'b0;
    bit          have_cur = 1'b0;
    exp_t        cur;
    int          run = 0;
    int          entry = 0;

    always @(negedge ckht) begin
        if (!mon_en) begin
            started  = 1'b0;
            have_cur = 1'b0;
        end else begin
            now = {anode, sseg, dp};
            if (!started || now != prev) begin
                if (have_cur && cur.len != 0) begin
                    n_checks++;
                    if (run != cur.len) begin
                        n_err++;
                        $display("FAIL run_len entry %0d: got %0d cycles, want %0d",
                                 entry - 1, run, cur.len);
                    end
                end
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_change: anode=%h sseg=%h dp=%b, nothing expected",
                             anode, sseg, dp);
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    n_checks++;
                    if (anode !== cur.an || sseg !== cur.ss || dp !== cur.dp) begin
                        n_err++;
                        $display("FAIL entry %0d: got anode=%h sseg=%h dp=%b, want anode=%h sseg=%h dp=%b",
                                 entry, anode, sseg, dp, cur.an, cur.ss, cur.dp);
                    end
                end
                run     = 1;
                prev    = now;
                started = 1'b1;
                entry++;
            end else begin
                run++;
            end
        end
    end

    task automatic check_off(input string name);
        n_checks++;
        if (anode !== 12'hFFF || sseg !== 7'h7F || dp !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got anode=%h sseg=%h dp=%b, want anode=fff sseg=7f dp=1",
                     name, anode, sseg, dp);
        end
    endtask

    // Async reset with an immediate output check; monitor starts after the first edge
    task automatic apply_reset(input logic [11:0] mask, input logic [11:0] dpr);
        mon_en = 1'b0;
        @(posedge ckht);
        #2 rst_n = 1'b0;
        #1 check_off("reset_immediate");
        data_in   = DATA;
        ena_12led = mask;
        dp_in     = dpr;
        repeat (2) @(posedge ckht);
        #2 rst_n = 1'b1;
        @(posedge ckht);
        #1 mon_en = 1'b1;
    endtask

    task automatic push_blank();
        q.push_back('{an: 12'hFFF, ss: 7'h7F, dp: 1'b1, len: 4});
    endtask

    task automatic push_slot(input int i);
        exp_t e;
        e.an  = ena_12led[i] ? ~(12'h001 << i) : 12'hFFF;
        e.ss  = glyph_tab[data_in[4*i +: 4]];
        e.dp  = ~(dp_in[i] & ena_12led[i]);
        e.len = 0;
        q.push_back(e);
    endtask

    // nt ticks spaced 20 cycles; bogus adds a pulse on the 2nd blanking cycle
    task automatic run_scan(input int nt, input bit bogus);
        push_blank();
        for (int i = 0; i <= nt; i++) begin
            push_slot(i % 12);
            if (i < nt) push_blank();
        end
        repeat (10) @(posedge ckht);
        #1;
        for (int t = 0; t < nt; t++) begin
            ena_scan = 1'b1;
            @(posedge ckht);
            #1 ena_scan = 1'b0;
            if (bogus) begin
                @(posedge ckht);
                #1 ena_scan = 1'b1;
                @(posedge ckht);
                #1 ena_scan = 1'b0;
                repeat (17) @(posedge ckht);
            end else begin
                repeat (19) @(posedge ckht);
            end
            #1;
        end
    endtask

    task automatic drain(input string name);
        repeat (10) @(posedge ckht);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s drain: %0d entries left, want 0", name, q.size());
        end
    endtask

    initial begin
        data_in   = DATA;
        ena_12led = 12'hFFF;
        dp_in     = 12'h000;

        // Full refresh walk 0..11 and back to 0, with dash and blank codes
        apply_reset(12'hFFF, 12'h000);
        run_scan(12, 1'b0);
        drain("walk");

        // Masked digits 0,3,6,9 keep their slots dark; dp only on lit digits
        apply_reset(12'b1101_1011_0110, 12'hFFF);
        run_scan(11, 1'b0);
        drain("mask");

        // Ticks during blanking are dropped
        apply_reset(12'hFFF, 12'h000);
        run_scan(4, 1'b1);
        drain("blank_tick");

        // Reset in the middle of digit 7, then restart from digit 0
        apply_reset(12'hFFF, 12'h080);
        run_scan(7, 1'b0);
        drain("to_idx7");
        n_checks++;
        if (anode !== 12'hF7F || dp !== 1'b0) begin
            n_err++;
            $display("FAIL idx7_shown: got anode=%h dp=%b, want anode=f7f dp=0", anode, dp);
        end
        apply_reset(12'hFFF, 12'h080);
        run_scan(1, 1'b0);
        drain("restart");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/quet_12led.md
QUET_12LED -- requirements
Module: quet_12led

Interface
REQ-001 SHALL have parameter GUARD_CYC, default 4, ckht cycles of all-anodes-off blanking between digits (range 1..15).
REQ-002 SHALL have port ckht  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena_scan  input  1  one-cycle scan tick (nominal 1 kHz); advances the displayed digit.
REQ-005 SHALL have port data_in  input  48  twelve 4-bit digit codes; digit i at bits [4i+3:4i].
REQ-006 SHALL have port ena_12led  input  12  per-digit visibility mask from the time-setting counter; 1 = lit, 0 = dark (blink off-phase).
REQ-007 SHALL have port dp_in  input  12  per-digit decimal point request, 1 = on.
REQ-008 SHALL have port anode  output  12  digit select, active-low, at most one bit low.
REQ-009 SHALL have port sseg  output  7  segments g..a, active-low.
REQ-010 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-011 SHALL implement FSM {BLANK, SHOW} with 4-bit digit index idx (0..11) and 4-bit guard counter gcnt.
REQ-012 In SHOW, ena_scan=1 SHALL move to BLANK and clear gcnt on the next edge; ena_scan=0 SHALL hold SHOW.
REQ-013 In BLANK, gcnt SHALL increment each cycle; at gcnt=GUARD_CYC-1 the FSM SHALL enter SHOW and idx SHALL advance by one.
REQ-014 idx SHALL wrap 11 -> 0; values 12..15 are unreachable and, if present, SHALL be treated as 0 on the next advance.
REQ-015 ena_scan asserted during BLANK SHALL be ignored (not queued).
REQ-016 In BLANK, anode SHALL be 12'hFFF, sseg 7'h7F, dp 1.
REQ-017 In SHOW, anode[idx] SHALL be 0 iff ena_12led[idx]=1; a masked digit keeps its full time slot with anode all-high (uniform brightness).
REQ-018 In SHOW, sseg SHALL show the glyph of data_in[idx]: codes 0-9 decimal glyphs, 0xA '-' (g only), 0xB-0xF blank.
REQ-019 In SHOW, dp SHALL be ~(dp_in[idx] & ena_12led[idx]).
REQ-020 anode, sseg, dp SHALL be registered; they reflect state/inputs of cycle n at cycle n+1 (latency one ckht).
REQ-021 data_in, ena_12led, dp_in SHALL be sampled live every cycle of SHOW; a mask change mid-slot takes effect one cycle later.
REQ-022 Full 12-digit refresh period SHALL be 12 scan ticks plus 12*GUARD_CYC cycles of blanking when ticks arrive only in SHOW.

Reset
REQ-023 rst_n=0 SHALL immediately force anode=12'hFFF, sseg=7'h7F, dp=1, state=BLANK, idx=11, gcnt=0.
REQ-024 After rst_n rises, the first SHOW slot SHALL be idx=0, entered GUARD_CYC cycles after the first active edge.
REQ-025 Reset asserted mid-slot SHALL abandon the slot with no partial glyph output on the following edge.

Structure
REQ-026 Shared package SHALL hold NUM_DIGITS=12, glyph constants for 0-9, dash and blank, and the state encoding.
REQ-027 Glyph lookup SHALL be a separate combinational sub-module bcd_to_7seg (4-bit code in, 7-bit active-low out).
REQ-028 The scan FSM, counters and output registers SHALL reside in quet_12led.

Verification
REQ-029 Reset release, GUARD_CYC=4, ena_12led=12'hFFF, data_in digit0=5 -> anode=12'hFFF for 4 cycles, then anode=12'hFFE, sseg=7'h12.
REQ-030 Twelve ena_scan ticks spaced 20 cycles -> anode low bit walks 0..11 then back to 0, each change preceded by exactly 4 all-off cycles.
REQ-031 ena_12led=12'b110110110110 (digits 0, 3, 6, 9 masked), dp_in=12'hFFF -> during slots 0, 3, 6, 9 anode=12'hFFF and dp=1; other slots lit with dp=0.
REQ-032 ena_scan pulsed on the 2nd cycle of BLANK -> pulse ignored; idx advances exactly once.
REQ-033 data_in digit=0xA -> sseg=7'h3F; digit=0xC -> sseg=7'h7F.
REQ-034 rst_n pulsed low mid-SHOW at idx=7 -> outputs all-high same cycle; after release the scan restarts at idx=0.
